// File: rtl/mdu_div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU).
// Radix-2 restoring shift-subtract: one quotient bit per clock, with
// valid/ready handshakes on both the request and the result side.
module mdu_div_seq #(
    parameter int dataW = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [dataW-1:0] result,
    output logic             busy
);

    localparam int CntW = $clog2(dataW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [dataW-1:0]  rem_q, rem_d;
    logic [dataW-1:0]  quo_q, quo_d;
    logic [dataW-1:0]  dvsr_q, dvsr_d;
    logic              quo_neg_q, quo_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              is_rem_q, is_rem_d;
    logic [dataW-1:0]  result_q, result_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic              is_signed;
    logic              overflow;
    logic [dataW:0]    shifted;
    logic [dataW:0]    trial;

    // Next-state and datapath: accept/special-case decode, one restoring step per CALC cycle, sign fix-up.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        is_rem_d    = is_rem_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        is_signed   = ~op[0];
        overflow    = is_signed
                      && (A == {1'b1, {(dataW-1){1'b0}}})
                      && (B == {dataW{1'b1}});
        shifted     = {rem_q, quo_q[dataW-1]};
        trial       = shifted - {1'b0, dvsr_q};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    is_rem_d  = op[1];
                    quo_neg_d = is_signed & (A[dataW-1] ^ B[dataW-1]);
                    rem_neg_d = is_signed & A[dataW-1];
                    if (B == '0) begin
                        result_d    = op[1] ? A : {dataW{1'b1}};
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (overflow) begin
                        result_d    = op[1] ? '0 : A;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        quo_d   = (is_signed && A[dataW-1]) ? -A : A;
                        dvsr_d  = (is_signed && B[dataW-1]) ? -B : B;
                        rem_d   = '0;
                        cnt_d   = CntW'(dataW - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // A clear borrow bit means the shifted remainder was >= divisor.
                if (!trial[dataW]) begin
                    rem_d = trial[dataW-1:0];
                    quo_d = {quo_q[dataW-2:0], 1'b1};
                end else begin
                    rem_d = shifted[dataW-1:0];
                    quo_d = {quo_q[dataW-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            S_FIX: begin
                if (is_rem_q) begin
                    result_d = rem_neg_q ? -rem_q : rem_q;
                end else begin
                    result_d = quo_neg_q ? -quo_q : quo_q;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // State and registered outputs; reset discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            is_rem_q    <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            is_rem_q    <= is_rem_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Self-checking bench for mdu_div_seq: directed RV32M cases, back-pressure,
// mid-operation reset and randomized operations against a plain-arithmetic model.
module tb_mdu_div_seq;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          busy;

    int n_compared;
    int n_mismatched;

    mdu_div_seq #(.dataW(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M divide semantics written directly from the instruction rules.
    function automatic logic [31:0] ref_model(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (b == 32'd0) return f_op[1] ? a : 32'hFFFF_FFFF;
        if (f_op[0] == 1'b0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f_op[1] ? 32'd0 : a;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        return f_op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_latency(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (f_op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 2;
    endfunction

    // Issue one request and wait (bounded) for out_valid, counting edges from the accept edge.
    task automatic applyStimulus(input logic [1:0] s_op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("in_ready_before_req", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        A  = a;
        B  = b;
        op = s_op;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            A  = $urandom;
            B  = $urandom;
            op = 2'($urandom);
            @(posedge clock);
            #1;
            lat++;
        end
        res = result;
    endtask

    // Take the result and confirm out_valid drops with the block back in IDLE.
    task automatic consume_result();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_drop", {31'd0, out_valid}, 32'd0);
        checkOutput("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [1:0] s_op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        applyStimulus(s_op, a, b, res, lat);
        checkOutput(tag, res, exp);
        checkOutput({tag, "_lat"}, lat, exp_lat);
        consume_result();
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          lat;
        int          seen;

        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A  = '0;
        B  = '0;
        op = 2'b00;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        // Directed operations with expected values worked out by hand.
        run_check("div_100_m7",    2'b00, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
        run_check("rem_100_m7",    2'b10, 32'd100,        32'hFFFF_FFF9, 32'h0000_0002, 34);
        run_check("rem_m100_7",    2'b10, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE, 34);
        run_check("divu_max_2",    2'b01, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF, 34);
        run_check("remu_max_2",    2'b11, 32'hFFFF_FFFF,  32'd2,        32'h0000_0001, 34);
        run_check("divu_14c83",    2'b01, 32'h0001_4C83,  32'h0000_0100, 32'h0000_014C, 34);
        run_check("div_by_zero",   2'b00, 32'd9,          32'd0,        32'hFFFF_FFFF, 1);
        run_check("remu_by_zero",  2'b11, 32'd9,          32'd0,        32'h0000_0009, 1);
        run_check("div_overflow",  2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_check("rem_overflow",  2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Back-pressure: result held while out_ready is low, pending request waits for IDLE.
        applyStimulus(2'b00, 32'd100, 32'hFFFF_FFF9, res, lat);
        checkOutput("bp_first", res, 32'hFFFF_FFF2);
        held = result;
        @(negedge clock);
        in_valid = 1'b1;
        A  = 32'd1000;
        B  = 32'd3;
        op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_result_hold", result, held);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checkOutput("b2b_result", result, 32'd333);
        checkOutput("b2b_lat", lat, 34);
        consume_result();

        // Reset in the middle of CALC discards the operation.
        @(negedge clock);
        in_valid = 1'b1;
        A  = 32'd12345;
        B  = 32'hFFFF_FFFD;
        op = 2'b00;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1;
        end
        checkOutput("rstmid_no_valid", seen, 0);
        run_check("divu_50_5", 2'b01, 32'd50, 32'd5, 32'h0000_000A, 34);

        // Randomized operations, biased toward the special cases and small divisors.
        for (int n = 0; n < 60; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2: rb = $urandom_range(1, 16);
                3: rb = 32'hFFFF_FFFF - $urandom_range(0, 16);
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, res, lat);
            checkOutput("rand_result", res, ref_model(rop, ra, rb));
            checkOutput("rand_lat", lat, ref_latency(rop, ra, rb));
            consume_result();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
